// File: rtl/mem_rf_pkg.sv
// ---------------------------------------------------------------------------
// mem_rf_pkg
// Shared definitions for the mem_rf register-file slice.
//   mem_rf_state_t       : controller state (zero-fill / ready)
//   mem_rf_reset_state() : state entered while rst_n is low, chosen by the
//                          zero-fill option of the instance
// ---------------------------------------------------------------------------
package mem_rf_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mem_rf_state_t;

    function automatic mem_rf_state_t mem_rf_reset_state(input bit clear_on_reset);
        return clear_on_reset ? ST_INIT : ST_READY;
    endfunction

endpackage

// File: rtl/mem_rf_array.sv
// ---------------------------------------------------------------------------
// mem_rf_array
// DEPTH x DATA_W storage with one write port and one registered read port.
// The storage itself has no reset; only the read register does.
//   clk, rst_n            : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port, committed at the rising edge
//   rd_en/rd_addr         : read request, result appears after the edge
//   byp_en/byp_data       : when set with rd_en, byp_data is captured instead
//                           of the array word (same-edge write forwarding)
//   rd_data/rd_valid      : registered read result and its one-cycle strobe
// ---------------------------------------------------------------------------
module mem_rf_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              byp_en,
    input  logic [DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_data only moves on an accepted read, so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= byp_en ? byp_data : mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/mem_rf_param.sv
// ---------------------------------------------------------------------------
// mem_rf_param
// Parameterised register file with optional zero-fill after reset.
//   clk, rst_n            : clock, async active-low reset
//   wr_en/wr_addr/wr_data : write request (ignored while filling)
//   rd_en/rd_addr         : read request (ignored while filling)
//   rd_data/rd_valid      : registered read data, one-cycle valid strobe
//   init_busy             : high while the zero-fill runs
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_INIT  | writing 0 to word fill_cnt each cycle, requests dropped
//   ST_READY | normal operation, write-first on same-address collision
// ---------------------------------------------------------------------------
module mem_rf_param
    import mem_rf_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_busy
);

    mem_rf_state_t     state;
    logic [ADDR_W-1:0] fill_cnt;

    logic              filling;
    logic              accept_wr;
    logic              accept_rd;
    logic              arr_wr_en;
    logic [ADDR_W-1:0] arr_wr_addr;
    logic [DATA_W-1:0] arr_wr_data;
    logic              byp_en;

    // The fill ends on the cycle that clears the all-ones address, so it
    // takes exactly DEPTH cycles; init_busy drops together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= mem_rf_reset_state(CLEAR_ON_RESET);
            fill_cnt  <= '0;
            init_busy <= CLEAR_ON_RESET;
        end else if (state == ST_INIT) begin
            if (fill_cnt == '1) begin
                state     <= ST_READY;
                fill_cnt  <= '0;
                init_busy <= 1'b0;
            end else begin
                fill_cnt  <= fill_cnt + 1'b1;
            end
        end else begin
            init_busy <= 1'b0;
        end
    end

    assign filling   = (state == ST_INIT);
    assign accept_wr = !filling && wr_en;
    assign accept_rd = !filling && rd_en;

    // During the fill the write port belongs to the fill counter.
    assign arr_wr_en   = filling || accept_wr;
    assign arr_wr_addr = filling ? fill_cnt : wr_addr;
    assign arr_wr_data = filling ? '0 : wr_data;

    // Same-edge write and read of one word: the read sees the new data.
    assign byp_en = accept_wr && (wr_addr == rd_addr);

    mem_rf_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (arr_wr_en),
        .wr_addr  (arr_wr_addr),
        .wr_data  (arr_wr_data),
        .rd_en    (accept_rd),
        .rd_addr  (rd_addr),
        .byp_en   (byp_en),
        .byp_data (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_mem_rf_param.sv
// ---------------------------------------------------------------------------
// tb_mem_rf_param
// Directed bench for mem_rf_param: a default instance (8x16, zero-fill) is
// checked every cycle against a behavioural model, and a second instance
// (16x64, no fill) is checked with literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_rf_param;

    logic        clk;
    logic        rst_n;

    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        init_busy;

    logic        wr_en2;
    logic [5:0]  wr_addr2;
    logic [15:0] wr_data2;
    logic        rd_en2;
    logic [5:0]  rd_addr2;
    logic [15:0] rd_data2;
    logic        rd_valid2;
    logic        init_busy2;

    int n_vec = 0;
    int n_err = 0;

    mem_rf_param #(
        .DATA_W         (8),
        .ADDR_W         (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_busy (init_busy)
    );

    mem_rf_param #(
        .DATA_W         (16),
        .ADDR_W         (6),
        .CLEAR_ON_RESET (1'b0)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en2),
        .wr_addr   (wr_addr2),
        .wr_data   (wr_data2),
        .rd_en     (rd_en2),
        .rd_addr   (rd_addr2),
        .rd_data   (rd_data2),
        .rd_valid  (rd_valid2),
        .init_busy (init_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default instance -----------
    // fill_left counts zero-fill cycles still owed; a fill clears word
    // (16 - fill_left). Outside the fill: write first, then read.
    logic [7:0] m_mem [16];
    int         fill_left  = 16;
    logic [7:0] m_rd_data  = 8'h00;
    logic       m_rd_valid = 1'b0;

    always @(negedge rst_n) begin
        fill_left  = 16;
        m_rd_data  = 8'h00;
        m_rd_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (fill_left > 0) begin
                m_mem[16 - fill_left] = 8'h00;
                fill_left--;
                m_rd_valid = 1'b0;
            end else begin
                if (wr_en) m_mem[wr_addr] = wr_data;
                m_rd_valid = rd_en;
                if (rd_en) m_rd_data = m_mem[rd_addr];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_rd_valid",  32'(rd_valid),  32'(m_rd_valid));
        chk("model_init_busy", 32'(init_busy), 32'(fill_left > 0));
        chk("model_rd_data",   32'(rd_data),   32'(m_rd_data));
    end

    bit busy2_seen = 1'b0;
    always @(posedge clk) begin
        #1;
        if (init_busy2) busy2_seen = 1'b1;
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                         input logic re, input logic [3:0] ra);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!init_busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    logic [7:0] wbytes [16];
    int         nbusy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0; wr_addr  = '0; wr_data  = '0; rd_en  = 1'b0; rd_addr  = '0;
        wr_en2   = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_en2 = 1'b0; rd_addr2 = '0;

        repeat (3) @(negedge clk);
        chk("reset_init_busy",  32'(init_busy),  32'd1);
        chk("reset_rd_valid",   32'(rd_valid),   32'd0);
        chk("reset_rd_data",    32'(rd_data),    32'h00);
        chk("reset_init_busy2", 32'(init_busy2), 32'd0);
        chk("reset_rd_data2",   32'(rd_data2),   32'h0000);

        // Release with write and read requests held during the whole fill.
        rst_n   = 1'b1;
        wr_en   = 1'b1; wr_addr = 4'd3; wr_data = 8'hFF;
        rd_en   = 1'b1; rd_addr = 4'd3;
        count_busy(nbusy);
        chk("fill_cycles", 32'(nbusy), 32'd16);
        wr_en = 1'b0; rd_en = 1'b0;

        // All words read back zero, including the one written during fill.
        for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        chk("init_ignored_addr3", 32'(rd_data), 32'h00);

        // Fill with random bytes, then read back-to-back.
        for (int i = 0; i < 16; i++) begin
            wbytes[i] = 8'($urandom_range(0, 255));
            drive(1'b1, 4'(i), wbytes[i], 1'b0, 4'd0);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
            if (i > 0) begin
                chk("b2b_valid", 32'(rd_valid), 32'd1);
                chk("b2b_data",  32'(rd_data),  32'(wbytes[i-1]));
            end
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        chk("b2b_valid_last", 32'(rd_valid), 32'd1);
        chk("b2b_data_last",  32'(rd_data),  32'(wbytes[15]));
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        chk("valid_drops", 32'(rd_valid), 32'd0);
        chk("data_holds",  32'(rd_data),  32'(wbytes[15]));

        // Write-first collision on address 5.
        drive(1'b1, 4'd5, 8'h11, 1'b0, 4'd0);
        drive(1'b1, 4'd5, 8'hA5, 1'b1, 4'd5);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        chk("wfirst_data",  32'(rd_data),  32'hA5);
        chk("wfirst_valid", 32'(rd_valid), 32'd1);
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        chk("wfirst_later", 32'(rd_data), 32'hA5);

        // Write 7 and read 2 on the same edge do not interact.
        drive(1'b1, 4'd2, 8'h5A, 1'b0, 4'd0);
        drive(1'b1, 4'd7, 8'h3C, 1'b1, 4'd2);
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
        chk("diff_addr_rd2", 32'(rd_data), 32'h5A);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        chk("diff_addr_rd7", 32'(rd_data), 32'h3C);

        // Reset mid-fill: first reset with rd_data non-zero, then again at fill cycle 7.
        drive(1'b1, 4'd10, 8'h77, 1'b1, 4'd5);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_data",  32'(rd_data),   32'h00);
        chk("async_rst_busy",  32'(init_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        chk("midfill_busy", 32'(init_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midfill_rst_data", 32'(rd_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(nbusy);
        chk("refill_cycles", 32'(nbusy), 32'd16);
        for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd10);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        chk("refill_addr10", 32'(rd_data), 32'h00);

        // Second instance: 16-bit data, 64 words, no zero-fill.
        @(negedge clk);
        wr_en2 = 1'b1; wr_addr2 = 6'd63; wr_data2 = 16'hBEEF;
        @(negedge clk);
        wr_en2 = 1'b0; rd_en2 = 1'b1; rd_addr2 = 6'd63;
        @(negedge clk);
        rd_en2 = 1'b0;
        chk("p2_rd63",       32'(rd_data2),  32'hBEEF);
        chk("p2_rd63_valid", 32'(rd_valid2), 32'd1);
        wr_en2 = 1'b1; wr_addr2 = 6'd0; wr_data2 = 16'h1234;
        rd_en2 = 1'b1; rd_addr2 = 6'd0;
        @(negedge clk);
        wr_en2 = 1'b0; rd_en2 = 1'b0;
        chk("p2_wfirst", 32'(rd_data2), 32'h1234);
        @(negedge clk);
        chk("p2_valid_drop", 32'(rd_valid2), 32'd0);
        chk("p2_hold",       32'(rd_data2),  32'h1234);
        chk("p2_busy_never", 32'(busy2_seen), 32'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
